// File: rtl/game_flow_ctrl.sv
// Game round sequencer: IDLE -> START -> PLAY -> RESULT, with per-player HP,
// hit cooldowns, winner decode and background/caption selection.
module game_flow_ctrl #(
  parameter int HP_INIT       = 7,
  parameter int START_FRAMES  = 120,
  parameter int RESULT_FRAMES = 300,
  parameter int HIT_COOLDOWN  = 30
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_tick,
  input  logic       i_start,
  input  logic       i_hit1,
  input  logic       i_hit2,
  input  logic       i_shield1,
  input  logic       i_shield2,
  output logic [1:0] o_state,
  output logic       o_play_en,
  output logic       o_round_rst,
  output logic [2:0] o_hp1,
  output logic [2:0] o_hp2,
  output logic [3:0] o_bg_id,
  output logic       o_caption_en,
  output logic [3:0] o_caption_id,
  output logic [1:0] o_winner
);

  localparam int FC_MAX = (START_FRAMES > RESULT_FRAMES) ? START_FRAMES : RESULT_FRAMES;
  localparam int FC_W   = $clog2(FC_MAX + 1);
  localparam int CD_W   = (HIT_COOLDOWN > 0) ? $clog2(HIT_COOLDOWN + 1) : 1;

  localparam logic [FC_W-1:0] START_LAST  = FC_W'(START_FRAMES - 1);
  localparam logic [FC_W-1:0] RESULT_LAST = FC_W'(RESULT_FRAMES - 1);
  localparam logic [CD_W-1:0] CD_LOAD     = CD_W'(HIT_COOLDOWN);
  localparam logic [2:0]      HP_LOAD     = 3'(HP_INIT);

  localparam logic [3:0] ID_MAP       = 4'd0;
  localparam logic [3:0] ID_WIN_CAP   = 4'd9;
  localparam logic [3:0] ID_LOSE_CAP  = 4'd10;
  localparam logic [3:0] ID_IDLE_BG   = 4'd11;
  localparam logic [3:0] ID_START_CAP = 4'd12;
  localparam logic [3:0] ID_START_BG  = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_PLAY   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic [CD_W-1:0] cd1_q, cd1_d, cd2_q, cd2_d;
  logic [2:0]      hp1_q, hp1_d, hp2_q, hp2_d;
  logic [1:0]      win_q, win_d;
  logic            round_rst_q, round_rst_d;
  logic            play_en_q, play_en_d;
  logic [3:0]      bg_q, bg_d;
  logic            cap_en_q, cap_en_d;
  logic [3:0]      cap_id_q, cap_id_d;

  always_comb begin
    state_d     = state_q;
    fc_d        = fc_q;
    cd1_d       = cd1_q;
    cd2_d       = cd2_q;
    hp1_d       = hp1_q;
    hp2_d       = hp2_q;
    win_d       = win_q;
    round_rst_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_START;
      end
      S_START: begin
        if (i_frame_tick) begin
          if (fc_q == START_LAST) begin
            state_d     = S_PLAY;
            round_rst_d = 1'b1;
            hp1_d       = HP_LOAD;
            hp2_d       = HP_LOAD;
            cd1_d       = '0;
            cd2_d       = '0;
            win_d       = 2'd0;
          end else begin
            fc_d = fc_q + FC_W'(1);
          end
        end
      end
      S_PLAY: begin
        if (i_frame_tick) begin
          if (cd1_q != '0) cd1_d = cd1_q - CD_W'(1);
          if (cd2_q != '0) cd2_d = cd2_q - CD_W'(1);
        end
        // Hits are qualified by the pre-tick cooldown; a load overrides the decrement.
        if (i_hit1 && !i_shield1 && (cd1_q == '0)) begin
          hp1_d = (hp1_q == 3'd0) ? 3'd0 : hp1_q - 3'd1;
          cd1_d = CD_LOAD;
        end
        if (i_hit2 && !i_shield2 && (cd2_q == '0)) begin
          hp2_d = (hp2_q == 3'd0) ? 3'd0 : hp2_q - 3'd1;
          cd2_d = CD_LOAD;
        end
        // Winner encoding falls out of {p1 dead, p2 dead}: 1=p1 wins, 2=p2 wins, 3=draw.
        if ((hp1_d == 3'd0) || (hp2_d == 3'd0)) begin
          state_d = S_RESULT;
          win_d   = {hp1_d == 3'd0, hp2_d == 3'd0};
        end
      end
      S_RESULT: begin
        if (i_frame_tick) begin
          if (fc_q == RESULT_LAST) state_d = S_IDLE;
          else                     fc_d    = fc_q + FC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) fc_d = '0;

    play_en_d = (state_d == S_PLAY);
    cap_en_d  = (state_d != S_PLAY);
    case (state_d)
      S_IDLE:  bg_d = ID_IDLE_BG;
      S_START: bg_d = ID_START_BG;
      default: bg_d = ID_MAP;
    endcase
    if (state_d == S_RESULT) cap_id_d = (win_d == 2'd1) ? ID_WIN_CAP : ID_LOSE_CAP;
    else                     cap_id_d = ID_START_CAP;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      fc_q        <= '0;
      cd1_q       <= '0;
      cd2_q       <= '0;
      hp1_q       <= HP_LOAD;
      hp2_q       <= HP_LOAD;
      win_q       <= 2'd0;
      round_rst_q <= 1'b0;
      play_en_q   <= 1'b0;
      bg_q        <= ID_IDLE_BG;
      cap_en_q    <= 1'b1;
      cap_id_q    <= ID_START_CAP;
    end else begin
      state_q     <= state_d;
      fc_q        <= fc_d;
      cd1_q       <= cd1_d;
      cd2_q       <= cd2_d;
      hp1_q       <= hp1_d;
      hp2_q       <= hp2_d;
      win_q       <= win_d;
      round_rst_q <= round_rst_d;
      play_en_q   <= play_en_d;
      bg_q        <= bg_d;
      cap_en_q    <= cap_en_d;
      cap_id_q    <= cap_id_d;
    end
  end

  assign o_state      = state_q;
  assign o_play_en    = play_en_q;
  assign o_round_rst  = round_rst_q;
  assign o_hp1        = hp1_q;
  assign o_hp2        = hp2_q;
  assign o_bg_id      = bg_q;
  assign o_caption_en = cap_en_q;
  assign o_caption_id = cap_id_q;
  assign o_winner     = win_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: round sequencing, hit/shield/cooldown rules,
// win/draw decode, RESULT timeout and reset priority.
module tb_game_flow_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_frame_tick = 1'b0;
  logic       i_start = 1'b0;
  logic       i_hit1 = 1'b0;
  logic       i_hit2 = 1'b0;
  logic       i_shield1 = 1'b0;
  logic       i_shield2 = 1'b0;
  logic [1:0] o_state;
  logic       o_play_en;
  logic       o_round_rst;
  logic [2:0] o_hp1;
  logic [2:0] o_hp2;
  logic [3:0] o_bg_id;
  logic       o_caption_en;
  logic [3:0] o_caption_id;
  logic [1:0] o_winner;

  int n_cmp = 0;
  int n_err = 0;

  game_flow_ctrl dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_frame_tick (i_frame_tick),
    .i_start      (i_start),
    .i_hit1       (i_hit1),
    .i_hit2       (i_hit2),
    .i_shield1    (i_shield1),
    .i_shield2    (i_shield2),
    .o_state      (o_state),
    .o_play_en    (o_play_en),
    .o_round_rst  (o_round_rst),
    .o_hp1        (o_hp1),
    .o_hp2        (o_hp2),
    .o_bg_id      (o_bg_id),
    .o_caption_en (o_caption_en),
    .o_caption_id (o_caption_id),
    .o_winner     (o_winner)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge i_clk);
    #1;
  endtask

  // One frame tick every other cycle.
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      i_frame_tick = 1'b1;
      clk1();
      i_frame_tick = 1'b0;
      clk1();
    end
  endtask

  task automatic hit(input logic h1, input logic h2);
    i_hit1 = h1;
    i_hit2 = h2;
    clk1();
    i_hit1 = 1'b0;
    i_hit2 = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    clk1();
    i_start = 1'b0;
  endtask

  initial begin
    // Reset state
    clk1();
    clk1();
    i_rst = 1'b0;
    check("rst_state", o_state, 0);
    check("rst_hp1", o_hp1, 7);
    check("rst_hp2", o_hp2, 7);
    check("rst_winner", o_winner, 0);
    check("rst_bg", o_bg_id, 11);
    check("rst_cap_en", o_caption_en, 1);
    check("rst_cap_id", o_caption_id, 12);
    check("rst_play_en", o_play_en, 0);
    check("rst_round_rst", o_round_rst, 0);

    // IDLE -> START -> PLAY
    pulse_start();
    check("start_state", o_state, 1);
    check("start_bg", o_bg_id, 13);
    check("start_cap_id", o_caption_id, 12);
    ticks(119);
    check("start_119", o_state, 1);
    check("start_rr_low", o_round_rst, 0);
    i_frame_tick = 1'b1;
    clk1();
    i_frame_tick = 1'b0;
    check("play_state", o_state, 2);
    check("play_round_rst", o_round_rst, 1);
    check("play_en", o_play_en, 1);
    check("play_bg", o_bg_id, 0);
    check("play_cap_en", o_caption_en, 0);
    check("play_hp1", o_hp1, 7);
    check("play_hp2", o_hp2, 7);
    clk1();
    check("round_rst_once", o_round_rst, 0);

    // Shield, cooldown and tick/hit ordering on player 1
    i_shield1 = 1'b1;
    hit(1'b1, 1'b0);
    i_shield1 = 1'b0;
    check("shield_hp1", o_hp1, 7);
    hit(1'b1, 1'b0);
    check("hit_hp1", o_hp1, 6);
    ticks(5);
    hit(1'b1, 1'b0);
    check("cooldown_hp1", o_hp1, 6);
    ticks(24);
    i_frame_tick = 1'b1;
    hit(1'b1, 1'b0);
    i_frame_tick = 1'b0;
    check("tick_hit_same_cycle", o_hp1, 6);
    hit(1'b1, 1'b0);
    check("after_cd_hp1", o_hp1, 5);
    check("hp2_untouched", o_hp2, 7);

    // Player 2 knocked out -> player 1 wins
    for (int i = 0; i < 6; i++) begin
      hit(1'b0, 1'b1);
      ticks(30);
    end
    check("hp2_at_1", o_hp2, 1);
    check("still_play", o_state, 2);
    hit(1'b0, 1'b1);
    check("p1win_state", o_state, 3);
    check("p1win_hp2", o_hp2, 0);
    check("p1win_winner", o_winner, 1);
    check("p1win_cap_id", o_caption_id, 9);
    check("p1win_cap_en", o_caption_en, 1);
    check("p1win_play_en", o_play_en, 0);
    check("p1win_bg", o_bg_id, 0);
    pulse_start();
    check("result_ignores_start", o_state, 3);
    hit(1'b1, 1'b0);
    check("result_ignores_hit", o_hp1, 5);
    ticks(299);
    check("result_299", o_state, 3);
    check("result_hold_win", o_winner, 1);
    ticks(1);
    check("result_to_idle", o_state, 0);
    check("idle_bg", o_bg_id, 11);
    check("idle_cap_id", o_caption_id, 12);

    // Second round: simultaneous hits down to a draw
    pulse_start();
    ticks(120);
    check("r2_state", o_state, 2);
    check("r2_hp1_reload", o_hp1, 7);
    check("r2_hp2_reload", o_hp2, 7);
    check("r2_winner_clr", o_winner, 0);
    hit(1'b1, 1'b1);
    check("dual_hp1", o_hp1, 6);
    check("dual_hp2", o_hp2, 6);
    ticks(30);
    for (int i = 0; i < 5; i++) begin
      hit(1'b1, 1'b1);
      ticks(30);
    end
    check("dual_hp1_at_1", o_hp1, 1);
    check("dual_hp2_at_1", o_hp2, 1);
    hit(1'b1, 1'b1);
    check("draw_state", o_state, 3);
    check("draw_hp1", o_hp1, 0);
    check("draw_hp2", o_hp2, 0);
    check("draw_winner", o_winner, 3);
    check("draw_cap_id", o_caption_id, 10);
    ticks(300);
    check("draw_to_idle", o_state, 0);

    // Hits outside PLAY are ignored
    hit(1'b1, 1'b1);
    check("idle_hit_hp1", o_hp1, 0);
    check("idle_hit_hp2", o_hp2, 0);
    pulse_start();
    hit(1'b1, 1'b1);
    check("start_hit_state", o_state, 1);
    check("start_hit_hp1", o_hp1, 0);

    // Reset mid-PLAY has priority over simultaneous inputs
    ticks(120);
    for (int i = 0; i < 4; i++) begin
      hit(1'b1, 1'b0);
      ticks(30);
    end
    check("r3_hp1_at_3", o_hp1, 3);
    i_rst = 1'b1;
    i_hit1 = 1'b1;
    i_start = 1'b1;
    i_frame_tick = 1'b1;
    clk1();
    i_rst = 1'b0;
    i_hit1 = 1'b0;
    i_start = 1'b0;
    i_frame_tick = 1'b0;
    check("midrst_state", o_state, 0);
    check("midrst_hp1", o_hp1, 7);
    check("midrst_play_en", o_play_en, 0);
    check("midrst_winner", o_winner, 0);
    check("midrst_bg", o_bg_id, 11);
    check("midrst_cap_en", o_caption_en, 1);
    check("midrst_cap_id", o_caption_id, 12);
    check("midrst_round_rst", o_round_rst, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
